// File: rtl/mem_stage_if.sv
// Bus bundle between the MEM stage and its neighbours: EX result in, SRAM load
// response in, WB/forwarding buses and the stall request out.
interface mem_stage_if;
    logic [5:0]   stall;
    logic [150:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic         data_sram_data_ok;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_id_bus;
    logic         stallreq_for_mem;

    modport master (
        output stall,
        output ex_to_mem_bus,
        output data_sram_rdata,
        output data_sram_data_ok,
        input  mem_to_wb_bus,
        input  mem_to_id_bus,
        input  stallreq_for_mem
    );

    modport slave (
        input  stall,
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        input  data_sram_data_ok,
        output mem_to_wb_bus,
        output mem_to_id_bus,
        output stallreq_for_mem
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EX result, waits for the load response,
// aligns/extends load data and drives the WB and forwarding buses.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    mem_stage_if.slave  mif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_nxt_s;
    logic [150:0] bus_r;
    logic [31:0]  rdata_buf_r;

    logic         capture_s;
    logic         bubble_s;
    logic [3:0]   sel_s;
    logic [65:0]  hilo_s;
    logic [4:0]   inst_load_s;
    logic [31:0]  pc_s;
    logic         sel_rf_res_s;
    logic         rf_we_s;
    logic [4:0]   rf_waddr_s;
    logic [31:0]  ex_result_s;
    logic [31:0]  raw_s;
    logic [31:0]  rf_wdata_s;
    logic         unused_s;

    // Lane select and extension for lw/lb/lbu/lh/lhu; ld = {lw, lb, lbu, lh, lhu}.
    function automatic logic [31:0] align_load(input logic [31:0] raw,
                                               input logic [3:0]  sel,
                                               input logic [4:0]  ld);
        logic [7:0]  b;
        logic [15:0] h;
        logic        ok;
        logic [31:0] res;
        b   = 8'd0;
        h   = 16'd0;
        ok  = 1'b1;
        res = 32'd0;
        if (ld[4]) begin
            res = raw;
        end else if (ld[3] | ld[2]) begin
            case (sel)
                4'b0001: b = raw[7:0];
                4'b0010: b = raw[15:8];
                4'b0100: b = raw[23:16];
                4'b1000: b = raw[31:24];
                default: ok = 1'b0;
            endcase
            if (!ok)
                res = 32'd0;
            else if (ld[3])
                res = {{24{b[7]}}, b};
            else
                res = {24'd0, b};
        end else if (ld[1] | ld[0]) begin
            case (sel)
                4'b0011: h = raw[15:0];
                4'b1100: h = raw[31:16];
                default: ok = 1'b0;
            endcase
            if (!ok)
                res = 32'd0;
            else if (ld[1])
                res = {{16{h[15]}}, h};
            else
                res = {16'd0, h};
        end else begin
            res = 32'd0;
        end
        return res;
    endfunction

    assign capture_s    = ~mif.stall[3];
    assign bubble_s     = mif.stall[3] & ~mif.stall[4];

    assign sel_s        = bus_r[150:147];
    assign hilo_s       = bus_r[146:81];
    assign inst_load_s  = bus_r[80:76];
    assign pc_s         = bus_r[75:44];
    assign sel_rf_res_s = bus_r[38];
    assign rf_we_s      = bus_r[37];
    assign rf_waddr_s   = bus_r[36:32];
    assign ex_result_s  = bus_r[31:0];

    // SRAM enable/byte-write fields and the other stall lanes are not consumed here.
    assign unused_s = ^{mif.stall[5], mif.stall[2:0], bus_r[43:39]};

    // EX->MEM pipeline register: bubble takes priority over capture.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            bus_r <= 151'd0;
        else if (bubble_s)
            bus_r <= 151'd0;
        else if (capture_s)
            bus_r <= mif.ex_to_mem_bus;
        else
            bus_r <= bus_r;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_r <= ST_IDLE;
        else
            state_r <= state_nxt_s;
    end

    // Keep the load word so a stalled stage can keep presenting it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rdata_buf_r <= 32'd0;
        else if ((state_r == ST_WAIT) && mif.data_sram_data_ok)
            rdata_buf_r <= mif.data_sram_rdata;
        else
            rdata_buf_r <= rdata_buf_r;
    end

    // Next state: a capture decides alone; a bubble empties the stage.
    always_comb begin
        state_nxt_s = state_r;
        if (capture_s) begin
            if (|mif.ex_to_mem_bus[80:76])
                state_nxt_s = ST_WAIT;
            else
                state_nxt_s = ST_IDLE;
        end else if (bubble_s) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (mif.data_sram_data_ok)
                        state_nxt_s = ST_HOLD;
                    else
                        state_nxt_s = ST_WAIT;
                end
                ST_HOLD: state_nxt_s = ST_HOLD;
                ST_IDLE: state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Source of the load word: live SRAM data on the response cycle, buffer afterwards.
    always_comb begin
        raw_s = 32'd0;
        case (state_r)
            ST_WAIT: raw_s = mif.data_sram_rdata;
            ST_HOLD: raw_s = rdata_buf_r;
            default: raw_s = 32'd0;
        endcase
    end

    // Write-back value; forced to zero while the response is still outstanding.
    always_comb begin
        rf_wdata_s = 32'd0;
        if ((state_r == ST_WAIT) && !mif.data_sram_data_ok)
            rf_wdata_s = 32'd0;
        else if (sel_rf_res_s)
            rf_wdata_s = align_load(raw_s, sel_s, inst_load_s);
        else
            rf_wdata_s = ex_result_s;
    end

    assign mif.stallreq_for_mem = (state_r == ST_WAIT) & ~mif.data_sram_data_ok;
    assign mif.mem_to_wb_bus    = {hilo_s, pc_s, rf_we_s, rf_waddr_s, rf_wdata_s};
    assign mif.mem_to_id_bus    = {hilo_s, rf_we_s, rf_waddr_s, rf_wdata_s};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed tables, hand sequences for
// stall/hold/reset corners, and random traffic against a behavioural model.
module tb_mem_stage;

    logic clk;
    logic resetn;
    mem_stage_if mif();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .mif    (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] LW  = 5'b10000;
    localparam logic [4:0] LB  = 5'b01000;
    localparam logic [4:0] LBU = 5'b00100;
    localparam logic [4:0] LH  = 5'b00010;
    localparam logic [4:0] LHU = 5'b00001;
    localparam logic [5:0] ALL = 6'b111111;

    int vectors;
    int miscompares;

    // Model: the instruction held in MEM, and where its load stands
    // (0 = nothing pending, 1 = awaiting response, 2 = response held).
    logic [150:0] m_bus;
    int           m_phase;
    logic [31:0]  m_buf;

    typedef struct {
        logic [4:0]  ld;
        logic [3:0]  sel;
        logic        sel_rf;
        logic [31:0] exres;
        logic [31:0] exp_wdata;
        logic        exp_stallreq;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [150:0] mk(input logic [3:0] sel, input logic [65:0] hilo,
                                        input logic [4:0] ld, input logic [31:0] pc,
                                        input logic sel_rf, input logic we,
                                        input logic [4:0] wa, input logic [31:0] res);
        return {sel, hilo, ld, pc, (ld != 5'd0), 4'd0, sel_rf, we, wa, res};
    endfunction

    // Reference load value from arithmetic on the returned word.
    function automatic logic [31:0] ref_load(input logic [150:0] b, input logic [31:0] word);
        logic [4:0]  ld;
        logic [3:0]  sel;
        logic [31:0] v;
        int          lane;
        ld   = b[80:76];
        sel  = b[150:147];
        lane = -1;
        if (ld[4]) return word;
        if (ld[3] || ld[2]) begin
            for (int i = 0; i < 4; i++)
                if (sel == (4'd1 << i)) lane = i;
            if (lane < 0) return 32'd0;
            v = (word >> (8 * lane)) & 32'h0000_00FF;
            if (ld[3] && v[7]) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (ld[1] || ld[0]) begin
            if (sel == 4'b0011) v = word & 32'h0000_FFFF;
            else if (sel == 4'b1100) v = word >> 16;
            else return 32'd0;
            if (ld[1] && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] rd, input logic dok);
        logic [31:0] word;
        if (m_phase == 1 && !dok) return 32'd0;
        if (!m_bus[38]) return m_bus[31:0];
        word = (m_phase == 1) ? rd : (m_phase == 2) ? m_buf : 32'd0;
        return ref_load(m_bus, word);
    endfunction

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] st, input logic [150:0] ex,
                         input logic [31:0] rd, input logic dok);
        mif.stall             = st;
        mif.ex_to_mem_bus     = ex;
        mif.data_sram_rdata   = rd;
        mif.data_sram_data_ok = dok;
        #2;
    endtask

    task automatic model_check(input string tag);
        logic [31:0] w;
        w = ref_wdata(mif.data_sram_rdata, mif.data_sram_data_ok);
        chk({tag, " wb"}, mif.mem_to_wb_bus,
            {m_bus[146:81], m_bus[75:44], m_bus[37], m_bus[36:32], w});
        chk({tag, " id"}, {32'd0, mif.mem_to_id_bus},
            {32'd0, m_bus[146:81], m_bus[37], m_bus[36:32], w});
        chk({tag, " stallreq"}, {135'd0, mif.stallreq_for_mem},
            {135'd0, (m_phase == 1) && !mif.data_sram_data_ok});
    endtask

    task automatic model_reset();
        m_bus   = 151'd0;
        m_phase = 0;
        m_buf   = 32'd0;
    endtask

    // Clock one edge and move the model with the inputs currently applied.
    task automatic advance();
        logic [150:0] nb;
        int           np;
        logic [31:0]  nbuf;
        nb   = m_bus;
        np   = m_phase;
        nbuf = m_buf;
        if (!mif.stall[3]) begin
            nb = mif.ex_to_mem_bus;
            np = (mif.ex_to_mem_bus[80:76] != 5'd0) ? 1 : 0;
        end else if (!mif.stall[4]) begin
            nb = 151'd0;
            np = 0;
        end else if (m_phase == 1 && mif.data_sram_data_ok) begin
            nbuf = mif.data_sram_rdata;
            np   = 2;
        end
        @(posedge clk);
        m_bus   = nb;
        m_phase = np;
        m_buf   = nbuf;
        #1;
    endtask

    logic [150:0] b1;
    logic [150:0] b2;
    logic [65:0]  hilo_c;
    int           stall_cnt;

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();

        tbl[0]  = '{LB,   4'b1000, 1'b1, 32'h0, 32'hFFFF_FF80, 1'b0};
        tbl[1]  = '{LBU,  4'b1000, 1'b1, 32'h0, 32'h0000_0080, 1'b0};
        tbl[2]  = '{LH,   4'b1100, 1'b1, 32'h0, 32'hFFFF_80FF, 1'b0};
        tbl[3]  = '{LHU,  4'b0011, 1'b1, 32'h0, 32'h0000_7F01, 1'b0};
        tbl[4]  = '{LB,   4'b0001, 1'b1, 32'h0, 32'h0000_0001, 1'b0};
        tbl[5]  = '{LBU,  4'b0100, 1'b1, 32'h0, 32'h0000_00FF, 1'b0};
        tbl[6]  = '{LB,   4'b0100, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0};
        tbl[7]  = '{LB,   4'b0010, 1'b1, 32'h0, 32'h0000_007F, 1'b0};
        tbl[8]  = '{LW,   4'b1111, 1'b1, 32'h0, 32'h80FF_7F01, 1'b0};
        tbl[9]  = '{LH,   4'b0110, 1'b1, 32'h0, 32'h0000_0000, 1'b0};
        tbl[10] = '{5'd0, 4'b0000, 1'b0, 32'h0000_1234, 32'h0000_1234, 1'b0};

        resetn = 1'b0;
        drive(6'd0, 151'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset wb", mif.mem_to_wb_bus, 136'd0);
        chk("reset stallreq", {135'd0, mif.stallreq_for_mem}, 136'd0);
        resetn = 1'b1;

        // Reset asserted while a load is waiting.
        b1 = mk(4'b1111, 66'd0, LW, 32'h0000_4000, 1'b1, 1'b1, 5'd3, 32'h0);
        drive(6'd0, b1, 32'd0, 1'b0);
        advance();
        drive(ALL, b1, 32'd0, 1'b0);
        model_check("pre-reset wait");
        #1 resetn = 1'b0;
        #1;
        chk("async reset wb", mif.mem_to_wb_bus, 136'd0);
        chk("async reset id", {32'd0, mif.mem_to_id_bus}, 136'd0);
        chk("async reset stallreq", {135'd0, mif.stallreq_for_mem}, 136'd0);
        model_reset();
        @(posedge clk);
        #1 resetn = 1'b1;
        drive(ALL, b1, 32'h1111_2222, 1'b1);
        model_check("stray data_ok");
        advance();
        drive(ALL, b1, 32'd0, 1'b0);
        chk("idle after stray", {135'd0, mif.stallreq_for_mem}, 136'd0);
        model_check("idle after stray");
        advance();

        // lw with response three cycles after MEM entry.
        b1 = mk(4'b1111, 66'd0, LW, 32'h0000_8000, 1'b1, 1'b1, 5'd5, 32'h0000_0100);
        drive(6'd0, b1, 32'd0, 1'b0);
        advance();
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(ALL, b1, 32'h0, 1'b0);
            if (mif.stallreq_for_mem) stall_cnt++;
            model_check("lw wait");
            advance();
        end
        drive(ALL, b1, 32'hDEAD_BEEF, 1'b1);
        chk("lw stall cycles", 136'(stall_cnt), 136'd3);
        chk("lw data", {104'd0, mif.mem_to_wb_bus[31:0]}, {104'd0, 32'hDEAD_BEEF});
        chk("lw waddr", {131'd0, mif.mem_to_wb_bus[36:32]}, {131'd0, 5'd5});
        chk("lw stallreq on data_ok", {135'd0, mif.stallreq_for_mem}, 136'd0);
        model_check("lw data_ok");
        advance();

        // Alignment table: load captured, response on its first MEM cycle.
        for (int i = 0; i < 11; i++) begin
            b1 = mk(tbl[i].sel, 66'd0, tbl[i].ld, 32'h0000_1000 + 32'(i), tbl[i].sel_rf,
                    1'b1, 5'(i + 1), tbl[i].exres);
            drive(6'd0, b1, 32'd0, 1'b0);
            advance();
            drive(ALL, b1, 32'h80FF_7F01, 1'b1);
            chk($sformatf("table %0d wdata", i), {104'd0, mif.mem_to_wb_bus[31:0]},
                {104'd0, tbl[i].exp_wdata});
            chk($sformatf("table %0d stallreq", i), {135'd0, mif.stallreq_for_mem},
                {135'd0, tbl[i].exp_stallreq});
            model_check("table");
            advance();
        end

        // Response arrives under a downstream stall, then held.
        b1 = mk(4'b1111, 66'd0, LW, 32'h0000_2000, 1'b1, 1'b1, 5'd9, 32'h0);
        drive(6'd0, b1, 32'd0, 1'b0);
        advance();
        drive(ALL, b1, 32'hCAFE_0000, 1'b1);
        model_check("hold entry");
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(ALL, b1, 32'h5A5A_0000 + 32'(i), (i == 1));
            chk("hold wdata", {104'd0, mif.mem_to_wb_bus[31:0]}, {104'd0, 32'hCAFE_0000});
            chk("hold stallreq", {135'd0, mif.stallreq_for_mem}, 136'd0);
            model_check("hold");
            advance();
        end

        // Back-to-back loads: second captured on the first one's data_ok cycle.
        b1 = mk(4'b1111, 66'd0, LW, 32'h0000_3000, 1'b1, 1'b1, 5'd7, 32'h0);
        b2 = mk(4'b0011, 66'd0, LHU, 32'h0000_3004, 1'b1, 1'b1, 5'd8, 32'h0);
        drive(6'd0, b1, 32'd0, 1'b0);
        advance();
        drive(6'd0, b2, 32'h1357_9BDF, 1'b1);
        chk("b2b first", {104'd0, mif.mem_to_wb_bus[31:0]}, {104'd0, 32'h1357_9BDF});
        model_check("b2b first");
        advance();
        drive(ALL, b2, 32'h0, 1'b0);
        chk("b2b second waits", {135'd0, mif.stallreq_for_mem}, {135'd0, 1'b1});
        model_check("b2b wait");
        advance();
        drive(ALL, b2, 32'hFFFF_8001, 1'b1);
        chk("b2b second", {104'd0, mif.mem_to_wb_bus[31:0]}, {104'd0, 32'h0000_8001});
        model_check("b2b second");
        advance();

        // Pass-through of hilo, then a bubble.
        hilo_c = {1'b1, 32'hAAAA_5555, 1'b1, 32'h1234_5678};
        b1 = mk(4'b0000, hilo_c, 5'd0, 32'hBFC0_0010, 1'b0, 1'b1, 5'd2, 32'h0000_0042);
        drive(6'd0, b1, 32'd0, 1'b0);
        advance();
        drive(ALL, b1, 32'd0, 1'b0);
        chk("hilo wb", {70'd0, mif.mem_to_wb_bus[135:70]}, {70'd0, hilo_c});
        chk("hilo id", {70'd0, mif.mem_to_id_bus[103:38]}, {70'd0, hilo_c});
        model_check("pass-through");
        drive(6'b001000, b1, 32'd0, 1'b0);
        advance();
        drive(ALL, b1, 32'd0, 1'b0);
        chk("bubble wb", mif.mem_to_wb_bus, 136'd0);
        model_check("bubble");
        advance();

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            logic [4:0]  ld;
            logic [3:0]  sel;
            logic [5:0]  st;
            int          pick;
            pick = int'($urandom_range(0, 5));
            ld   = (pick == 0) ? 5'd0 : (5'd1 << (pick - 1));
            case ($urandom_range(0, 6))
                0: sel = 4'b0001;
                1: sel = 4'b0010;
                2: sel = 4'b0100;
                3: sel = 4'b1000;
                4: sel = 4'b0011;
                5: sel = 4'b1100;
                default: sel = 4'($urandom_range(0, 15));
            endcase
            b1 = mk(sel, {2'($urandom_range(0, 3)), $urandom, $urandom}, ld, $urandom,
                    (ld != 5'd0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
            st    = 6'($urandom_range(0, 63));
            st[3] = ($urandom_range(0, 2) != 0);
            st[4] = ($urandom_range(0, 4) != 0);
            drive(st, b1, $urandom, ($urandom_range(0, 2) == 0));
            model_check("rand");
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
